// File: rtl/hough_peak_finder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hough_peak_finder_pkg
//  Purpose  : Shared accumulator geometry, peak record type and FSM encoding
//             for the Hough peak finder.
//  Revision : 1.0 - initial release
// ============================================================================
package hough_peak_finder_pkg;

    localparam int ACCUM_BUFF_WIDTH = 8;
    localparam int THETAS           = 16;
    localparam int THETA_BITS       = $clog2(THETAS);
    localparam int RHO_RANGE        = 8;
    localparam int RHOS             = 4;
    localparam int RHO_IDX_BITS     = $clog2(RHO_RANGE);
    localparam int RHO_OUT_BITS     = 16;

    // One retained peak; an all-zero record is an empty slot.
    typedef struct packed {
        logic                          valid;
        logic [ACCUM_BUFF_WIDTH-1:0]   votes;
        logic signed [RHO_OUT_BITS-1:0] rho;
        logic [THETA_BITS-1:0]         theta;
    } peak_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Accumulator row index to centred, signed rho.
    function automatic logic signed [RHO_OUT_BITS-1:0] rho_from_idx(
        input logic [RHO_IDX_BITS-1:0] idx
    );
        return $signed(RHO_OUT_BITS'(idx) - RHO_OUT_BITS'(RHOS));
    endfunction

endpackage
`default_nettype wire

// File: rtl/hough_peak_finder_if.sv
`default_nettype none
// ============================================================================
//  Module   : hough_peak_finder_if
//  Purpose  : Control, beat stream and peak-list bundle of the peak finder.
//  Revision : 1.0 - initial release
// ============================================================================
interface hough_peak_finder_if #(
    parameter int THETA_UNROLL = 4,
    parameter int NUM_PEAKS    = 2
);
    import hough_peak_finder_pkg::*;

    logic                                           start;
    logic [ACCUM_BUFF_WIDTH-1:0]                    threshold;
    logic                                           in_valid;
    logic                                           in_ready;
    logic [THETA_UNROLL-1:0][ACCUM_BUFF_WIDTH-1:0]  in_data;
    logic [RHO_IDX_BITS-1:0]                        in_rho_idx;
    logic [THETA_BITS-1:0]                          in_theta_base;
    logic                                           busy;
    logic                                           done;

    logic [NUM_PEAKS-1:0]                           left_valid;
    logic signed [NUM_PEAKS-1:0][RHO_OUT_BITS-1:0]  left_rho;
    logic [NUM_PEAKS-1:0][THETA_BITS-1:0]           left_theta;
    logic [NUM_PEAKS-1:0][ACCUM_BUFF_WIDTH-1:0]     left_votes;
    logic [NUM_PEAKS-1:0]                           right_valid;
    logic signed [NUM_PEAKS-1:0][RHO_OUT_BITS-1:0]  right_rho;
    logic [NUM_PEAKS-1:0][THETA_BITS-1:0]           right_theta;
    logic [NUM_PEAKS-1:0][ACCUM_BUFF_WIDTH-1:0]     right_votes;

    modport master (
        output start, threshold, in_valid, in_data, in_rho_idx, in_theta_base,
        input  in_ready, busy, done,
        input  left_valid, left_rho, left_theta, left_votes,
        input  right_valid, right_rho, right_theta, right_votes
    );

    modport slave (
        input  start, threshold, in_valid, in_data, in_rho_idx, in_theta_base,
        output in_ready, busy, done,
        output left_valid, left_rho, left_theta, left_votes,
        output right_valid, right_rho, right_theta, right_votes
    );

endinterface
`default_nettype wire

// File: rtl/hough_region_max.sv
`default_nettype none
// ============================================================================
//  Module   : hough_region_max
//  Purpose  : Stage 1 - picks the strongest above-threshold lane of one theta
//             region in a beat and registers it as that region's candidate.
//  Revision : 1.0 - initial release
// ============================================================================
module hough_region_max
    import hough_peak_finder_pkg::*;
#(
    parameter int THETA_UNROLL = 4,
    parameter int THETA_SPLIT  = 90,
    parameter bit IS_LEFT      = 1'b1
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           beat_i,
    input  logic [THETA_UNROLL-1:0][ACCUM_BUFF_WIDTH-1:0]  votes_i,
    input  logic [THETA_BITS-1:0]                          theta_base_i,
    input  logic [ACCUM_BUFF_WIDTH-1:0]                    threshold_i,
    input  logic signed [RHO_OUT_BITS-1:0]                 rho_i,
    output peak_t                                          cand_o
);

    logic [THETA_UNROLL-1:0]                 w_qual;
    logic [THETA_UNROLL-1:0][THETA_BITS-1:0] w_theta;
    peak_t                                   w_best;
    peak_t                                   cand_q;

    for (genvar l = 0; l < THETA_UNROLL; l++) begin : g_lane
        logic w_in_region;

        assign w_theta[l] = theta_base_i + THETA_BITS'(l);

        // Region membership uses the unwrapped theta so a beat can straddle the split.
        if (IS_LEFT) begin : g_left
            assign w_in_region = (int'(theta_base_i) + l) < THETA_SPLIT;
        end else begin : g_right
            assign w_in_region = (int'(theta_base_i) + l) >= THETA_SPLIT;
        end

        assign w_qual[l] = w_in_region && (votes_i[l] > threshold_i);
    end

    // Ascending-lane scan with a strict compare keeps the lowest theta on ties.
    always_comb begin
        w_best = '0;
        for (int l = 0; l < THETA_UNROLL; l++) begin
            if (w_qual[l] && (!w_best.valid || (votes_i[l] > w_best.votes))) begin
                w_best.valid = 1'b1;
                w_best.votes = votes_i[l];
                w_best.theta = w_theta[l];
                w_best.rho   = rho_i;
            end
        end
    end

    // Candidate register; empty whenever no beat was accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_q <= '0;
        end else if (beat_i) begin
            cand_q <= w_best;
        end else begin
            cand_q <= '0;
        end
    end

    assign cand_o = cand_q;

endmodule
`default_nettype wire

// File: rtl/hough_peak_finder.sv
`default_nettype none
// ============================================================================
//  Module   : hough_peak_finder
//  Purpose  : Scans a Hough accumulator stream and keeps the NUM_PEAKS
//             strongest peaks of the left and right theta regions.
//  Revision : 1.0 - initial release
// ============================================================================
module hough_peak_finder
    import hough_peak_finder_pkg::*;
#(
    parameter int THETA_UNROLL = 4,
    parameter int NUM_PEAKS    = 2,
    parameter int THETA_SPLIT  = 90,
    parameter int BEATS        = RHO_RANGE * THETAS / THETA_UNROLL
) (
    input  logic              clk,
    input  logic              rst,
    hough_peak_finder_if.slave pf
);

    localparam int BEAT_CNT_BITS = $clog2(BEATS + 1);
    localparam logic [BEAT_CNT_BITS-1:0] LAST_BEAT = BEAT_CNT_BITS'(BEATS - 1);

    state_t                     state_q, state_d;
    logic [BEAT_CNT_BITS-1:0]   beat_cnt_q, beat_cnt_d;
    logic                       drain_q, drain_d;
    logic                       w_accept;
    logic                       w_clear;
    logic signed [RHO_OUT_BITS-1:0] w_rho;

    assign w_accept = (state_q == ST_SCAN) && pf.in_valid;
    assign w_clear  = (state_q == ST_IDLE) && pf.start;
    assign w_rho    = rho_from_idx(pf.in_rho_idx);

    // Scan control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            drain_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            drain_q    <= drain_d;
        end
    end

    // Next state and handshake/status outputs; DRAIN lasts two cycles so both
    // pipeline stages settle before done.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        drain_d     = 1'b0;
        pf.in_ready = 1'b0;
        pf.busy     = 1'b0;
        pf.done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pf.start) begin
                    state_d    = ST_SCAN;
                    beat_cnt_d = '0;
                end
            end
            ST_SCAN: begin
                pf.in_ready = 1'b1;
                pf.busy     = 1'b1;
                if (w_accept) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d    = ST_DRAIN;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_CNT_BITS'(1);
                    end
                end
            end
            ST_DRAIN: begin
                pf.busy = 1'b1;
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = ST_DONE;
                    drain_d = 1'b0;
                end
            end
            ST_DONE: begin
                pf.done = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Region 0 is left (theta < THETA_SPLIT), region 1 is right.
    for (genvar r = 0; r < 2; r++) begin : g_region
        peak_t                 w_cand;
        peak_t [NUM_PEAKS-1:0] list_q, list_d;
        logic  [NUM_PEAKS-1:0] w_gt;

        hough_region_max #(
            .THETA_UNROLL (THETA_UNROLL),
            .THETA_SPLIT  (THETA_SPLIT),
            .IS_LEFT      (r == 0)
        ) u_region_max (
            .clk          (clk),
            .rst          (rst),
            .beat_i       (w_accept),
            .votes_i      (pf.in_data),
            .theta_base_i (pf.in_theta_base),
            .threshold_i  (pf.threshold),
            .rho_i        (w_rho),
            .cand_o       (w_cand)
        );

        // Each slot decides independently: keep, take the candidate, or take
        // the slot above. The list is sorted, so w_gt is 0..0 1..1 from slot 0.
        for (genvar k = 0; k < NUM_PEAKS; k++) begin : g_slot
            assign w_gt[k] = w_cand.valid &&
                             (!list_q[k].valid || (w_cand.votes > list_q[k].votes));

            if (k == 0) begin : g_head
                assign list_d[k] = w_gt[k] ? w_cand : list_q[k];
            end else begin : g_tail
                assign list_d[k] = !w_gt[k]    ? list_q[k]   :
                                   w_gt[k - 1] ? list_q[k-1] : w_cand;
            end

            if (r == 0) begin : g_left_out
                assign pf.left_valid[k] = list_q[k].valid;
                assign pf.left_rho[k]   = list_q[k].rho;
                assign pf.left_theta[k] = list_q[k].theta;
                assign pf.left_votes[k] = list_q[k].votes;
            end else begin : g_right_out
                assign pf.right_valid[k] = list_q[k].valid;
                assign pf.right_rho[k]   = list_q[k].rho;
                assign pf.right_theta[k] = list_q[k].theta;
                assign pf.right_votes[k] = list_q[k].votes;
            end
        end

        // Sorted peak list; wiped by an accepted start.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                list_q <= '0;
            end else if (w_clear) begin
                list_q <= '0;
            end else begin
                list_q <= list_d;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hough_peak_finder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hough_peak_finder
//  Purpose  : Self-checking bench for hough_peak_finder (directed + random).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hough_peak_finder;
    import hough_peak_finder_pkg::*;

    localparam int UNR   = 4;
    localparam int K     = 2;
    localparam int SPLIT = 8;
    localparam int BEATS = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails  = 0;

    hough_peak_finder_if #(.THETA_UNROLL(UNR), .NUM_PEAKS(K)) bus ();

    hough_peak_finder #(
        .THETA_UNROLL (UNR),
        .NUM_PEAKS    (K),
        .THETA_SPLIT  (SPLIT),
        .BEATS        (BEATS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pf  (bus)
    );

    always #5 clk = ~clk;

    // Beat list of the scan being run and the expected final lists.
    int b_rho  [BEATS];
    int b_base [BEATS];
    int b_v    [BEATS][UNR];
    int mat    [RHO_RANGE][THETAS];
    int exp_valid [2][K];
    int exp_votes [2][K];
    int exp_rho   [2][K];
    int exp_theta [2][K];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit in_region(input int rg, input int th);
        return (rg == 0) ? (th < SPLIT) : (th >= SPLIT);
    endfunction

    // Reference: per beat and region, the best qualifying lane (lowest theta
    // among the maxima); final list = top K candidates by votes, earlier first on ties.
    task automatic build_model(input int thr);
        int cv [2][BEATS];
        int cr [2][BEATS];
        int ct [2][BEATS];
        int n  [2];
        bit used [BEATS];
        n[0] = 0;
        n[1] = 0;
        for (int b = 0; b < BEATS; b++) begin
            for (int rg = 0; rg < 2; rg++) begin
                int maxv;
                int best_th;
                maxv = -1;
                for (int l = 0; l < UNR; l++)
                    if (in_region(rg, b_base[b] + l) && b_v[b][l] > thr && b_v[b][l] > maxv)
                        maxv = b_v[b][l];
                if (maxv >= 0) begin
                    best_th = 1000;
                    for (int l = 0; l < UNR; l++)
                        if (in_region(rg, b_base[b] + l) && b_v[b][l] == maxv && b_base[b] + l < best_th)
                            best_th = b_base[b] + l;
                    cv[rg][n[rg]] = maxv;
                    cr[rg][n[rg]] = b_rho[b] - RHOS;
                    ct[rg][n[rg]] = best_th;
                    n[rg]++;
                end
            end
        end
        for (int rg = 0; rg < 2; rg++) begin
            for (int i = 0; i < BEATS; i++) used[i] = 1'b0;
            for (int k = 0; k < K; k++) begin
                int best;
                best = -1;
                for (int i = 0; i < n[rg]; i++)
                    if (!used[i] && (best < 0 || cv[rg][i] > cv[rg][best])) best = i;
                if (best >= 0) begin
                    used[best] = 1'b1;
                    exp_valid[rg][k] = 1;
                    exp_votes[rg][k] = cv[rg][best];
                    exp_rho[rg][k]   = cr[rg][best];
                    exp_theta[rg][k] = ct[rg][best];
                end else begin
                    exp_valid[rg][k] = 0;
                    exp_votes[rg][k] = 0;
                    exp_rho[rg][k]   = 0;
                    exp_theta[rg][k] = 0;
                end
            end
        end
    endtask

    task automatic clear_matrix();
        for (int r = 0; r < RHO_RANGE; r++)
            for (int t = 0; t < THETAS; t++) mat[r][t] = 0;
    endtask

    // Row-major raster: rho outer, theta groups of UNR inner.
    task automatic beats_from_matrix();
        for (int r = 0; r < RHO_RANGE; r++)
            for (int g = 0; g < THETAS / UNR; g++) begin
                int b;
                b = r * (THETAS / UNR) + g;
                b_rho[b]  = r;
                b_base[b] = g * UNR;
                for (int l = 0; l < UNR; l++) b_v[b][l] = mat[r][g * UNR + l];
            end
    endtask

    task automatic drive_beat(input int b);
        bus.in_valid      = 1'b1;
        bus.in_rho_idx    = RHO_IDX_BITS'(b_rho[b]);
        bus.in_theta_base = THETA_BITS'(b_base[b]);
        for (int l = 0; l < UNR; l++) bus.in_data[l] = ACCUM_BUFF_WIDTH'(b_v[b][l]);
    endtask

    task automatic check_outputs(input string tag);
        for (int k = 0; k < K; k++) begin
            chk($sformatf("%s.L%0d.valid", tag, k), int'(bus.left_valid[k]), exp_valid[0][k]);
            chk($sformatf("%s.L%0d.votes", tag, k), int'(bus.left_votes[k]), exp_votes[0][k]);
            chk($sformatf("%s.L%0d.rho",   tag, k), int'($signed(bus.left_rho[k])), exp_rho[0][k]);
            chk($sformatf("%s.L%0d.theta", tag, k), int'(bus.left_theta[k]), exp_theta[0][k]);
            chk($sformatf("%s.R%0d.valid", tag, k), int'(bus.right_valid[k]), exp_valid[1][k]);
            chk($sformatf("%s.R%0d.votes", tag, k), int'(bus.right_votes[k]), exp_votes[1][k]);
            chk($sformatf("%s.R%0d.rho",   tag, k), int'($signed(bus.right_rho[k])), exp_rho[1][k]);
            chk($sformatf("%s.R%0d.theta", tag, k), int'(bus.right_theta[k]), exp_theta[1][k]);
        end
    endtask

    // Full scan; gappy inserts an idle cycle (junk data, valid low) before
    // each beat after the first and pulses start during one of them.
    task automatic run_scan(input int thr, input bit gappy, input string tag);
        int lat;
        build_model(thr);
        @(negedge clk);
        bus.threshold = ACCUM_BUFF_WIDTH'(thr);
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, ".in_ready"}, int'(bus.in_ready), 1);
        chk({tag, ".busy"}, int'(bus.busy), 1);
        for (int b = 0; b < BEATS; b++) begin
            if (gappy && b > 0) begin
                bus.in_valid = 1'b0;
                for (int l = 0; l < UNR; l++) bus.in_data[l] = 8'hFF;
                bus.start = (b == 5);
                @(negedge clk);
                bus.start = 1'b0;
            end
            drive_beat(b);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".done_latency"}, lat, 3);
        chk({tag, ".busy_at_done"}, int'(bus.busy), 0);
        check_outputs(tag);
        @(negedge clk);
        chk({tag, ".done_pulse"}, int'(bus.done), 0);
        chk({tag, ".idle_ready"}, int'(bus.in_ready), 0);
        bus.in_valid = 1'b1;
        for (int l = 0; l < UNR; l++) bus.in_data[l] = 8'hFE;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_outputs({tag, ".hold"});
    endtask

    initial begin
        int thr;
        bus.start         = 1'b0;
        bus.threshold     = '0;
        bus.in_valid      = 1'b0;
        bus.in_data       = '0;
        bus.in_rho_idx    = '0;
        bus.in_theta_base = '0;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset.in_ready", int'(bus.in_ready), 0);
        chk("reset.busy", int'(bus.busy), 0);
        chk("reset.done", int'(bus.done), 0);
        chk("reset.left_valid", int'(bus.left_valid), 0);
        chk("reset.right_valid", int'(bus.right_valid), 0);
        chk("reset.left_votes", int'(bus.left_votes), 0);

        // All-zero stream, threshold 0
        clear_matrix();
        beats_from_matrix();
        run_scan(0, 1'b0, "zero");

        // Three isolated peaks
        clear_matrix();
        mat[1][2]  = 50;
        mat[6][12] = 70;
        mat[3][5]  = 40;
        beats_from_matrix();
        run_scan(0, 1'b0, "three");
        chk("three.const.L0rho", int'($signed(bus.left_rho[0])), -3);
        chk("three.const.L0theta", int'(bus.left_theta[0]), 2);
        chk("three.const.L1votes", int'(bus.left_votes[1]), 40);
        chk("three.const.R0rho", int'($signed(bus.right_rho[0])), 2);
        chk("three.const.R1valid", int'(bus.right_valid[1]), 0);

        // Same data with stalls and a start during SCAN
        run_scan(0, 1'b1, "gappy");

        // Equal votes: lowest theta in the beat, earlier beat keeps slot 0
        clear_matrix();
        mat[0][1] = 30;
        mat[0][3] = 30;
        mat[2][4] = 30;
        beats_from_matrix();
        run_scan(0, 1'b0, "ties");
        chk("ties.const.L0theta", int'(bus.left_theta[0]), 1);
        chk("ties.const.L1theta", int'(bus.left_theta[1]), 4);

        // Threshold is exclusive
        clear_matrix();
        mat[2][10] = 30;
        mat[5][3]  = 31;
        beats_from_matrix();
        run_scan(30, 1'b0, "thresh");
        chk("thresh.const.L0votes", int'(bus.left_votes[0]), 31);
        chk("thresh.const.R0valid", int'(bus.right_valid[0]), 0);

        // Random beats, including unaligned bases that straddle the split
        for (int t = 0; t < 4; t++) begin
            for (int b = 0; b < BEATS; b++) begin
                b_rho[b]  = int'($urandom_range(0, RHO_RANGE - 1));
                b_base[b] = int'($urandom_range(0, THETAS - UNR));
                for (int l = 0; l < UNR; l++) begin
                    if ($urandom_range(0, 1) == 0) b_v[b][l] = 0;
                    else if (t % 2 == 1)           b_v[b][l] = int'($urandom_range(20, 23));
                    else                           b_v[b][l] = int'($urandom_range(1, 255));
                end
            end
            thr = (t % 2 == 1) ? int'($urandom_range(0, 21)) : int'($urandom_range(0, 120));
            run_scan(thr, (t == 3), $sformatf("rand%0d", t));
        end

        // Asynchronous reset mid-scan, then a clean rerun
        clear_matrix();
        mat[1][2]  = 50;
        mat[6][12] = 70;
        mat[3][5]  = 40;
        beats_from_matrix();
        @(negedge clk);
        bus.threshold = '0;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int b = 0; b < 10; b++) begin
            drive_beat(b);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst.in_ready", int'(bus.in_ready), 0);
        chk("rst.busy", int'(bus.busy), 0);
        chk("rst.done", int'(bus.done), 0);
        chk("rst.left_valid", int'(bus.left_valid), 0);
        chk("rst.left_votes", int'(bus.left_votes), 0);
        chk("rst.left_rho", int'(bus.left_rho), 0);
        chk("rst.left_theta", int'(bus.left_theta), 0);
        chk("rst.right_valid", int'(bus.right_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        run_scan(0, 1'b0, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hough_peak_finder.md
HOUGH_PEAK_FINDER -- requirements
Module: hough_peak_finder

Interface
REQ-001 Parameter THETA_UNROLL, 4, accumulator lanes per input beat (theta = theta_base + lane).
REQ-002 Parameter NUM_PEAKS, 2, peaks retained per region (K >= 1).
REQ-003 Parameter THETA_SPLIT, 90, first theta index of the right region; theta < THETA_SPLIT is the left region.
REQ-004 Parameter BEATS, RHO_RANGE*THETAS/THETA_UNROLL, input beats per scan.
REQ-005 clock  input  1  single clock, rising edge; reset  input  1  asynchronous, active-high.
REQ-006 start  input  1  one-cycle pulse that begins a scan.
REQ-007 threshold  input  ACCUM_BUFF_WIDTH  minimum vote count, exclusive.
REQ-008 in_valid  input  1; in_ready  output  1  (beat accepted when both high).
REQ-009 in_data  input  THETA_UNROLL x ACCUM_BUFF_WIDTH  lane vote counts.
REQ-010 in_rho_idx  input  clog2(RHO_RANGE); in_theta_base  input  THETA_BITS.
REQ-011 busy  output  1; done  output  1  one-cycle pulse at scan completion.
REQ-012 left_valid, right_valid  output  NUM_PEAKS  per-slot occupancy, slot 0 strongest.
REQ-013 left_rho, right_rho  output  NUM_PEAKS x 16 signed; left_theta, right_theta  output  NUM_PEAKS x THETA_BITS; left_votes, right_votes  output  NUM_PEAKS x ACCUM_BUFF_WIDTH.

Function
REQ-014 FSM states IDLE, SCAN, DRAIN, DONE; IDLE->SCAN on start; SCAN->DRAIN after BEATS accepted beats; DRAIN->DONE after 2 cycles; DONE->IDLE next cycle.
REQ-015 in_ready = 1 only in SCAN; in_valid outside SCAN ignored; busy = 1 in SCAN and DRAIN.
REQ-016 start in IDLE clears all slots (valid 0, fields 0); start in any other state is ignored.
REQ-017 Stage 1 (registered): per region, select lane with maximum vote among lanes of that region with votes > threshold; ties -> lowest theta; no qualifying lane -> no candidate.
REQ-018 Stage 1 emits at most one candidate per region per beat; a beat straddling THETA_SPLIT feeds both regions.
REQ-019 Stage 2 (registered): insert candidate into the region's sorted list, descending votes; strictly greater displaces; equal votes keep the earlier entry; slot K-1 drops off.
REQ-020 Output rho = in_rho_idx - RHOS, signed 16-bit; theta = in_theta_base + lane, THETA_BITS wide.
REQ-021 Beat-count latency: last beat accepted in cycle N -> done high in cycle N+3, with final lists valid that cycle.
REQ-022 Peak outputs held stable from done until next accepted start; done = 1 in DONE only.
REQ-023 Stalls (in_valid low during SCAN) pause the beat counter and insert no candidate.
REQ-024 Vote counts equal to threshold are rejected; threshold = 0 accepts any nonzero count.
REQ-025 Fewer than K qualifying candidates -> remaining slots valid 0, fields 0.

Reset
REQ-026 reset asynchronously forces IDLE, beat counter 0, pipeline registers empty, in_ready 0, busy 0, done 0, all slots valid 0 with rho/theta/votes 0.
REQ-027 reset mid-scan discards partial results; next start after reset release begins a clean scan.

Structure
REQ-028 ACCUM_BUFF_WIDTH, THETA_BITS, THETAS, RHO_RANGE, RHOS and a peak_t struct (votes, rho, theta, valid) in the shared globals package.
REQ-029 One sub-module hough_region_max performs the stage-1 lane reduction for one region, instantiated twice.
REQ-030 Sorted-list insertion is a parallel compare-and-shift over NUM_PEAKS slots, no loops across cycles.

Verification (THETA_UNROLL=4, THETAS=16, RHO_RANGE=8, RHOS=4, NUM_PEAKS=2, THETA_SPLIT=8, BEATS=32)
REQ-031 All-zero stream, threshold 0 -> done after 32 beats + 3 cycles; all valid bits 0.
REQ-032 Votes 50 at (rho_idx 1, theta 2), 70 at (rho_idx 6, theta 12), 40 at (rho_idx 3, theta 5), rest 0 -> left: slot0 rho -3 theta 2 votes 50, slot1 rho -1 theta 5 votes 40; right: slot0 rho 2 theta 12 votes 70, slot1 invalid.
REQ-033 Two equal 30-vote lanes, theta 1 and 3, same beat -> only theta 1 recorded; later 30 at theta 4 lands in slot1, not slot0.
REQ-034 threshold 30 with a 30-vote peak and a 31-vote peak -> only 31 recorded.
REQ-035 in_valid toggled every other cycle -> identical result to back-to-back run; start asserted during SCAN -> no effect.
REQ-036 reset asserted at beat 10 -> all outputs 0 immediately; fresh scan afterwards matches REQ-032 result.
